// File: rtl/prim_alert_sender.sv
// Peripheral-side alert sender. Local alert requests and handler pings are
// encoded as a four-phase differential handshake on alert_po/alert_no.
// Differential faults on the incoming ping/ack pairs are reported by driving
// the alert pair non-complementary (1,1 / 0,0 toggling) until they clear.
module prim_alert_sender #(
   parameter bit AsyncOn = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic alert_req_i,
   output logic alert_ack_o,
   input  logic ping_pi,
   input  logic ping_ni,
   input  logic ack_pi,
   input  logic ack_ni,
   output logic alert_po,
   output logic alert_no
);

   // Two synchronizer flops for asynchronous handlers, one register otherwise.
   // The local request runs through the same depth, so the alert path and the
   // ack path keep a fixed relative timing for either setting.
   localparam int unsigned SyncDepth = AsyncOn ? 2 : 1;

   typedef enum logic [2:0] {
      Idle   = 3'd0,
      AlPh1  = 3'd1,
      AlPh2  = 3'd2,
      PiPh1  = 3'd3,
      PiPh2  = 3'd4,
      Pause0 = 3'd5,
      Pause1 = 3'd6,
      SigInt = 3'd7
   } state_e;

   logic [SyncDepth-1:0] ping_p_q, ping_n_q, ack_p_q, ack_n_q, req_q;
   logic                 ping_p_s, ping_n_s, ack_p_s, ack_n_s, req_s;

   logic   ping_hist_q;
   logic   ping_event, sigint, ack_hi, ack_lo;
   state_e state_q, state_d;
   logic   ping_pending_q, ping_pending_d;
   logic   ping_rearm_q, ping_rearm_d;
   logic   alert_p_q, alert_p_d;
   logic   alert_n_q, alert_n_d;

   // Input stage: shift incoming pairs and the request through the sync flops.
   // Idle rails reset to the complementary p=0/n=1 so no fault is seen at reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ping_p_q <= '0;
         ping_n_q <= '1;
         ack_p_q  <= '0;
         ack_n_q  <= '1;
         req_q    <= '0;
      end else begin
         ping_p_q[0] <= ping_pi;
         ping_n_q[0] <= ping_ni;
         ack_p_q[0]  <= ack_pi;
         ack_n_q[0]  <= ack_ni;
         req_q[0]    <= alert_req_i;
         for (int i = 1; i < SyncDepth; i++) begin
            ping_p_q[i] <= ping_p_q[i-1];
            ping_n_q[i] <= ping_n_q[i-1];
            ack_p_q[i]  <= ack_p_q[i-1];
            ack_n_q[i]  <= ack_n_q[i-1];
            req_q[i]    <= req_q[i-1];
         end
      end
   end

   assign ping_p_s = ping_p_q[SyncDepth-1];
   assign ping_n_s = ping_n_q[SyncDepth-1];
   assign ack_p_s  = ack_p_q[SyncDepth-1];
   assign ack_n_s  = ack_n_q[SyncDepth-1];
   assign req_s    = req_q[SyncDepth-1];

   // A ping is a level change on a healthy (complementary) ping pair.
   assign ping_event = (ping_p_s != ping_hist_q) && (ping_p_s != ping_n_s);
   assign sigint     = (ping_p_s == ping_n_s) || (ack_p_s == ack_n_s);
   assign ack_hi     = ack_p_s && !ack_n_s;
   assign ack_lo     = !ack_p_s && ack_n_s;

   // Control state: FSM, ping bookkeeping and the registered alert pair.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= Idle;
         ping_hist_q    <= 1'b0;
         ping_pending_q <= 1'b0;
         ping_rearm_q   <= 1'b0;
         alert_p_q      <= 1'b0;
         alert_n_q      <= 1'b1;
      end else begin
         state_q        <= state_d;
         ping_hist_q    <= ping_p_s;
         ping_pending_q <= ping_pending_d;
         ping_rearm_q   <= ping_rearm_d;
         alert_p_q      <= alert_p_d;
         alert_n_q      <= alert_n_d;
      end
   end

   // Next-state, ping bookkeeping and handshake completion pulse.
   // ping_rearm remembers pings arriving during a ping handshake so that they
   // survive the clear at its end and trigger one more response.
   always_comb begin
      state_d        = state_q;
      alert_ack_o    = 1'b0;
      ping_pending_d = ping_pending_q | ping_event;
      ping_rearm_d   = 1'b0;

      unique case (state_q)
         Idle: begin
            if (req_s) begin
               state_d = AlPh1;
            end else if (ping_pending_q) begin
               state_d = PiPh1;
            end
         end
         AlPh1: begin
            if (ack_hi) state_d = AlPh2;
         end
         AlPh2: begin
            if (ack_lo) begin
               state_d        = Pause0;
               alert_ack_o    = 1'b1;
               ping_pending_d = ping_event;
            end
         end
         PiPh1: begin
            ping_rearm_d = ping_rearm_q | ping_event;
            if (ack_hi) state_d = PiPh2;
         end
         PiPh2: begin
            ping_rearm_d = ping_rearm_q | ping_event;
            if (ack_lo) begin
               state_d        = Pause0;
               ping_pending_d = ping_rearm_q | ping_event;
            end
         end
         Pause0: state_d = Pause1;
         Pause1: state_d = Idle;
         SigInt: begin
            if (!sigint) state_d = Idle;
         end
         default: state_d = Idle;
      endcase

      // A fault overrides everything; the interrupted request and any pending
      // ping are kept so they are served again once the pairs are healthy.
      if (sigint) begin
         state_d        = SigInt;
         alert_ack_o    = 1'b0;
         ping_pending_d = ping_pending_q | ping_event;
         ping_rearm_d   = 1'b0;
      end
   end

   // Alert pair encoding of the upcoming state; SigInt starts at 1,1 and then
   // inverts both rails every cycle.
   always_comb begin
      alert_p_d = 1'b0;
      alert_n_d = 1'b1;
      unique case (state_d)
         AlPh1, PiPh1: begin
            alert_p_d = 1'b1;
            alert_n_d = 1'b0;
         end
         SigInt: begin
            if (state_q == SigInt) begin
               alert_p_d = ~alert_p_q;
               alert_n_d = ~alert_p_q;
            end else begin
               alert_p_d = 1'b1;
               alert_n_d = 1'b1;
            end
         end
         default: begin
            alert_p_d = 1'b0;
            alert_n_d = 1'b1;
         end
      endcase
   end

   assign alert_po = alert_p_q;
   assign alert_no = alert_n_q;

endmodule

// File: tb/tb_prim_alert_sender.sv
// Directed bench for prim_alert_sender: one instance without and one with
// input synchronizers, driven cycle by cycle from a vector table.
module tb_prim_alert_sender;

   typedef struct packed {
      logic       sel;   // 0: AsyncOn=0 instance, 1: AsyncOn=1 instance
      logic       req;
      logic       pp;
      logic       pn;
      logic       ap;
      logic       an;
      logic [2:0] exp;   // {alert_po, alert_no, alert_ack_o}
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic req0 = 1'b0, pp0 = 1'b0, pn0 = 1'b1, ap0 = 1'b0, an0 = 1'b1;
   logic req1 = 1'b0, pp1 = 1'b0, pn1 = 1'b1, ap1 = 1'b0, an1 = 1'b1;
   logic po0, no0, aa0, po1, no1, aa1;

   int n_chk  = 0;
   int n_pass = 0;

   vec_t tbl[$];

   always #5 clk = ~clk;

   prim_alert_sender #(.AsyncOn(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .alert_req_i(req0), .alert_ack_o(aa0),
      .ping_pi(pp0), .ping_ni(pn0), .ack_pi(ap0), .ack_ni(an0),
      .alert_po(po0), .alert_no(no0)
   );

   prim_alert_sender #(.AsyncOn(1'b1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .alert_req_i(req1), .alert_ack_o(aa1),
      .ping_pi(pp1), .ping_ni(pn1), .ack_pi(ap1), .ack_ni(an1),
      .alert_po(po1), .alert_no(no1)
   );

   task automatic chk(input string name, input int idx, input logic [2:0] got,
                      input logic [2:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s[%0d] {po,no,ack} got %b expected %b", name, idx, got, exp);
   endtask

   function automatic vec_t mk(input logic sel, input logic r, input logic pp,
                               input logic pn, input logic ap, input logic an,
                               input logic po, input logic no, input logic aa);
      vec_t v;
      v.sel = sel; v.req = r; v.pp = pp; v.pn = pn; v.ap = ap; v.an = an;
      v.exp = {po, no, aa};
      return v;
   endfunction

   task automatic addn(input int n, input logic sel, input logic r,
                       input logic pp, input logic pn, input logic ap,
                       input logic an, input logic po, input logic no,
                       input logic aa);
      for (int i = 0; i < n; i++) tbl.push_back(mk(sel, r, pp, pn, ap, an, po, no, aa));
   endtask

   task automatic drive(input vec_t v);
      if (!v.sel) begin
         req0 = v.req; pp0 = v.pp; pn0 = v.pn; ap0 = v.ap; an0 = v.an;
      end else begin
         req1 = v.req; pp1 = v.pp; pn1 = v.pn; ap1 = v.ap; an1 = v.an;
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, check on the falling edge.
   task automatic apply(input vec_t v, input string name, input int idx);
      drive(v);
      @(negedge clk);
      chk(name, idx, v.sel ? {po1, no1, aa1} : {po0, no0, aa0}, v.exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Alert handshake, AsyncOn=0; request kept high to force a second one.
      addn(2, 0, 1,0,1, 0,1, 0,1,0);
      addn(2, 0, 1,0,1, 0,1, 1,0,0);
      addn(2, 0, 1,0,1, 1,0, 1,0,0);
      addn(1, 0, 1,0,1, 1,0, 0,1,0);
      addn(1, 0, 1,0,1, 0,1, 0,1,0);
      addn(1, 0, 1,0,1, 0,1, 0,1,1);
      addn(3, 0, 1,0,1, 0,1, 0,1,0);
      addn(1, 0, 1,0,1, 0,1, 1,0,0);
      addn(2, 0, 1,0,1, 1,0, 1,0,0);
      addn(1, 0, 1,0,1, 1,0, 0,1,0);
      addn(1, 0, 1,0,1, 0,1, 0,1,0);
      addn(1, 0, 1,0,1, 0,1, 0,1,1);
      addn(4, 0, 0,0,1, 0,1, 0,1,0);
      // Ping, plus a second ping toggle during the ping handshake.
      addn(3, 0, 0,1,0, 0,1, 0,1,0);
      addn(1, 0, 0,1,0, 0,1, 1,0,0);
      addn(1, 0, 0,0,1, 0,1, 1,0,0);
      addn(2, 0, 0,0,1, 1,0, 1,0,0);
      addn(1, 0, 0,0,1, 1,0, 0,1,0);
      addn(5, 0, 0,0,1, 0,1, 0,1,0);
      addn(2, 0, 0,0,1, 0,1, 1,0,0);
      addn(2, 0, 0,0,1, 1,0, 1,0,0);
      addn(1, 0, 0,0,1, 1,0, 0,1,0);
      addn(7, 0, 0,0,1, 0,1, 0,1,0);
      // Request and ping together: one alert handshake answers both.
      addn(2, 0, 1,1,0, 0,1, 0,1,0);
      addn(1, 0, 1,1,0, 0,1, 1,0,0);
      addn(2, 0, 1,1,0, 1,0, 1,0,0);
      addn(1, 0, 1,1,0, 1,0, 0,1,0);
      addn(1, 0, 1,1,0, 0,1, 0,1,0);
      addn(1, 0, 1,1,0, 0,1, 0,1,1);
      addn(6, 0, 0,1,0, 0,1, 0,1,0);
      // Ack pair stuck at 1,1 for four cycles during phase 1.
      addn(2, 0, 1,1,0, 0,1, 0,1,0);
      addn(2, 0, 1,1,0, 1,1, 1,0,0);
      addn(1, 0, 1,1,0, 1,1, 1,1,0);
      addn(1, 0, 1,1,0, 1,1, 0,0,0);
      addn(1, 0, 1,1,0, 0,1, 1,1,0);
      addn(1, 0, 1,1,0, 0,1, 0,0,0);
      addn(1, 0, 1,1,0, 0,1, 0,1,0);
      addn(1, 0, 1,1,0, 0,1, 1,0,0);
      addn(2, 0, 1,1,0, 1,0, 1,0,0);
      addn(1, 0, 1,1,0, 1,0, 0,1,0);
      addn(1, 0, 1,1,0, 0,1, 0,1,0);
      addn(1, 0, 1,1,0, 0,1, 0,1,1);
      addn(4, 0, 0,1,0, 0,1, 0,1,0);
      // Same alert stimulus on the synchronized instance: responses one cycle later.
      addn(3, 1, 1,0,1, 0,1, 0,1,0);
      addn(1, 1, 1,0,1, 0,1, 1,0,0);
      addn(3, 1, 1,0,1, 1,0, 1,0,0);
      addn(2, 1, 1,0,1, 0,1, 0,1,0);
      addn(1, 1, 1,0,1, 0,1, 0,1,1);
      addn(5, 1, 0,0,1, 0,1, 0,1,0);

      // Reset values on both instances.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_async0", 0, {po0, no0, aa0}, 3'b010);
      chk("reset_async1", 0, {po1, no1, aa1}, 3'b010);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "vec", i);

      // Reset in phase 2 on the cycle the completion pulse would appear.
      for (int i = 0; i < 8; i++) apply(tbl[i], "rst_pre", i);
      drive(mk(0, 1,0,1, 0,1, 0,1,0));
      #1 rst_n = 1'b0;
      #1 chk("rst_in_ph2", 0, {po0, no0, aa0}, 3'b010);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Request still high after release: fresh handshake.
      apply(mk(0, 1,0,1, 0,1, 0,1,0), "rst_fresh", 0);
      apply(mk(0, 1,0,1, 0,1, 0,1,0), "rst_fresh", 1);
      apply(mk(0, 1,0,1, 0,1, 1,0,0), "rst_fresh", 2);
      // Reset in phase 1 forces the pair back to idle immediately.
      drive(mk(0, 1,0,1, 0,1, 0,1,0));
      #1 rst_n = 1'b0;
      #1 chk("rst_in_ph1", 0, {po0, no0, aa0}, 3'b010);
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(mk(0, 0,0,1, 0,1, 0,1,0), "rst_idle", 0);
      apply(mk(0, 0,0,1, 0,1, 0,1,0), "rst_idle", 1);
      apply(mk(0, 0,0,1, 0,1, 0,1,0), "rst_idle", 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
